// File: rtl/joy_dir_if.sv
// Direction-path bundle between the input merger (master) and joy_dir_filter (slave).
interface joy_dir_if #(
   parameter int PLAYERS = 2
);
   logic                 ce;
   logic [1:0]           mode;
   logic [1:0]           rotate;
   logic [PLAYERS-1:0]   flip;
   logic [4*PLAYERS-1:0] in_dir;
   logic [4*PLAYERS-1:0] out_dir;
   logic [PLAYERS-1:0]   changed;

   modport master (
      output ce, mode, rotate, flip, in_dir,
      input  out_dir, changed
   );

   modport slave (
      input  ce, mode, rotate, flip, in_dir,
      output out_dir, changed
   );
endinterface

// File: rtl/joy_dir_filter.sv
// Per-player joystick conditioner: rotate/flip, two-flop sync, per-bit debounce, then
// reduction to 8-way, 4-way last-pressed, 4-way first-held or 2-way horizontal output.
module joy_dir_filter #(
   parameter int PLAYERS   = 2,
   parameter int DEB_TICKS = 3,
   parameter int DEB_W     = 4
) (
   input logic      clk,
   input logic      reset_n,
   joy_dir_if.slave bus
);

   localparam int               NB       = 4 * PLAYERS;
   localparam logic [DEB_W-1:0] CNT_ZERO = DEB_W'(32'd0);
   localparam logic [DEB_W-1:0] CNT_ONE  = DEB_W'(32'd1);
   localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_TICKS - 1);
   localparam logic [1:0]       MODE_8WAY   = 2'd0;
   localparam logic [1:0]       MODE_4LAST  = 2'd1;
   localparam logic [1:0]       MODE_4FIRST = 2'd2;
   localparam logic [1:0]       MODE_2WAY   = 2'd3;
   localparam logic [3:0]       LR_BITS     = 4'b0011;

   logic [NB-1:0]            s1_q, s1_d;
   logic [NB-1:0]            s2_q, s2_d;
   logic [NB-1:0]            stable_q, stable_d;
   logic [NB-1:0]            stable_dly_q, stable_dly_d;
   logic [NB-1:0][DEB_W-1:0] cnt_q, cnt_d;
   logic [PLAYERS-1:0][3:0]  mask_q, mask_d;
   logic [NB-1:0]            out_q, out_d;
   logic [PLAYERS-1:0]       changed_q, changed_d;
   logic [1:0]               mode_q, mode_d;
   logic                     mode_chg_s;
   logic [PLAYERS-1:0][3:0]  held_s, rise_s;

   // Bit order is {up, down, left, right}; r counts clockwise quarter turns.
   function automatic logic [3:0] rotate_dirs(input logic [3:0] d, input logic [1:0] r);
      logic [3:0] res;
      case (r)
         2'd0:    res = d;
         2'd1:    res = {d[1], d[0], d[2], d[3]};
         2'd2:    res = {d[2], d[3], d[0], d[1]};
         2'd3:    res = {d[0], d[1], d[3], d[2]};
         default: res = d;
      endcase
      return res;
   endfunction

   function automatic logic [3:0] top_bit(input logic [3:0] v);
      logic [3:0] res;
      if (v[3]) begin
         res = 4'b1000;
      end else if (v[2]) begin
         res = 4'b0100;
      end else if (v[1]) begin
         res = 4'b0010;
      end else if (v[0]) begin
         res = 4'b0001;
      end else begin
         res = 4'b0000;
      end
      return res;
   endfunction

   // A fresh press wins; otherwise keep the mask while its bit is still held.
   function automatic logic [3:0] last_pressed(input logic [3:0] held, input logic [3:0] rise,
                                               input logic [3:0] mask);
      logic [3:0] res;
      if (rise != 4'b0000) begin
         res = top_bit(rise);
      end else if ((held & mask) == 4'b0000) begin
         res = top_bit(held);
      end else begin
         res = mask;
      end
      return res;
   endfunction

   function automatic logic [3:0] first_held(input logic [3:0] held, input logic [3:0] mask);
      logic [3:0] res;
      if ((held & mask) == 4'b0000) begin
         res = top_bit(held);
      end else begin
         res = mask;
      end
      return res;
   endfunction

   function automatic logic [3:0] cancel_opposite(input logic [3:0] d);
      logic ud_ok;
      logic lr_ok;
      ud_ok = ~(d[3] & d[2]);
      lr_ok = ~(d[1] & d[0]);
      return {d[3] & ud_ok, d[2] & ud_ok, d[1] & lr_ok, d[0] & lr_ok};
   endfunction

   // Rotation/flip applied ahead of the synchroniser.
   always_comb begin
      s1_d = s1_q;
      for (int p = 0; p < PLAYERS; p++) begin
         s1_d[4*p +: 4] = rotate_dirs(bus.in_dir[4*p +: 4], bus.rotate + {bus.flip[p], 1'b0});
      end
      s2_d = s1_q;
   end

   // Per-bit debounce counter and stable value.
   always_comb begin
      stable_d     = stable_q;
      cnt_d        = cnt_q;
      stable_dly_d = stable_q;
      for (int i = 0; i < NB; i++) begin
         if (s2_q[i] == stable_q[i]) begin
            cnt_d[i] = CNT_ZERO;
         end else if (bus.ce) begin
            if (cnt_q[i] == CNT_LAST) begin
               stable_d[i] = s2_q[i];
               cnt_d[i]    = CNT_ZERO;
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
         end else begin
            cnt_d[i] = cnt_q[i];
         end
      end
   end

   // Held and newly-risen directions per player, plus mode-change detection.
   always_comb begin
      held_s     = '0;
      rise_s     = '0;
      mode_d     = bus.mode;
      mode_chg_s = (bus.mode != mode_q);
      for (int p = 0; p < PLAYERS; p++) begin
         held_s[p] = stable_q[4*p +: 4];
         rise_s[p] = stable_q[4*p +: 4] & ~stable_dly_q[4*p +: 4];
      end
   end

   // Mode reduction: new mask and output come from the same clk's stable/mask view.
   always_comb begin
      mask_d    = mask_q;
      out_d     = out_q;
      changed_d = '0;
      for (int p = 0; p < PLAYERS; p++) begin
         case (bus.mode)
            MODE_8WAY: begin
               mask_d[p]       = 4'b0000;
               out_d[4*p +: 4] = cancel_opposite(held_s[p]);
            end
            MODE_4LAST: begin
               if (mode_chg_s) begin
                  mask_d[p] = 4'b0000;
               end else begin
                  mask_d[p] = last_pressed(held_s[p], rise_s[p], mask_q[p]);
               end
               out_d[4*p +: 4] = held_s[p] & mask_d[p];
            end
            MODE_4FIRST: begin
               if (mode_chg_s) begin
                  mask_d[p] = 4'b0000;
               end else begin
                  mask_d[p] = first_held(held_s[p], mask_q[p]);
               end
               out_d[4*p +: 4] = held_s[p] & mask_d[p];
            end
            MODE_2WAY: begin
               if (mode_chg_s) begin
                  mask_d[p] = 4'b0000;
               end else begin
                  mask_d[p] = last_pressed(held_s[p] & LR_BITS, rise_s[p] & LR_BITS, mask_q[p]);
               end
               out_d[4*p +: 4] = held_s[p] & LR_BITS & mask_d[p];
            end
            default: begin
               mask_d[p]       = 4'b0000;
               out_d[4*p +: 4] = 4'b0000;
            end
         endcase
         changed_d[p] = (out_d[4*p +: 4] != out_q[4*p +: 4]);
      end
   end

   // State registers; reset overrides everything, including a debounce in progress.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1_q         <= '0;
         s2_q         <= '0;
         stable_q     <= '0;
         stable_dly_q <= '0;
         cnt_q        <= '0;
         mask_q       <= '0;
         out_q        <= '0;
         changed_q    <= '0;
         mode_q       <= 2'd0;
      end else begin
         s1_q         <= s1_d;
         s2_q         <= s2_d;
         stable_q     <= stable_d;
         stable_dly_q <= stable_dly_d;
         cnt_q        <= cnt_d;
         mask_q       <= mask_d;
         out_q        <= out_d;
         changed_q    <= changed_d;
         mode_q       <= mode_d;
      end
   end

   assign bus.out_dir = out_q;
   assign bus.changed = changed_q;

endmodule

// File: tb/tb_joy_dir_filter.sv
// Bench for joy_dir_filter: a DEB_TICKS=1 instance with ce tied high and a DEB_TICKS=3 instance.
module tb_joy_dir_filter;

   logic       clk;
   logic       rst_n;
   logic [1:0] mode;
   logic [1:0] rotate;
   logic [1:0] flip;
   logic [7:0] in_dir;
   logic       ce3;
   logic       ce3_rand;
   int         cyc;
   int         errors;
   int         checks;

   joy_dir_if #(.PLAYERS(2)) bus1 ();
   joy_dir_if #(.PLAYERS(2)) bus3 ();

   assign bus1.ce     = 1'b1;
   assign bus1.mode   = mode;
   assign bus1.rotate = rotate;
   assign bus1.flip   = flip;
   assign bus1.in_dir = in_dir;
   assign bus3.ce     = ce3;
   assign bus3.mode   = mode;
   assign bus3.rotate = rotate;
   assign bus3.flip   = flip;
   assign bus3.in_dir = in_dir;

   joy_dir_filter #(.PLAYERS(2), .DEB_TICKS(1), .DEB_W(4)) dut1 (
      .clk(clk), .reset_n(rst_n), .bus(bus1));
   joy_dir_filter #(.PLAYERS(2), .DEB_TICKS(3), .DEB_W(4)) dut3 (
      .clk(clk), .reset_n(rst_n), .bus(bus3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model, index [instance][player]; directions as compass angles.
   logic [3:0] m_s1 [2][2];
   logic [3:0] m_s2 [2][2];
   logic [3:0] m_stable [2][2];
   logic [3:0] m_sdel [2][2];
   logic [3:0] m_mask [2][2];
   logic [3:0] m_out [2][2];
   logic       m_chg [2][2];
   int         m_cnt [2][2][4];
   logic [1:0] m_mode_q [2];
   int         ang2bit [4] = '{3, 0, 2, 1};

   function automatic logic [3:0] first_of(input logic [3:0] v);
      for (int b = 3; b >= 0; b--) begin
         if (v[b]) return 4'(1 << b);
      end
      return 4'b0000;
   endfunction

   function automatic logic [7:0] model_out(input int k);
      return {m_out[k][1], m_out[k][0]};
   endfunction

   function automatic logic [1:0] model_chg(input int k);
      return {m_chg[k][1], m_chg[k][0]};
   endfunction

   task automatic model_step(input logic srst_n, input logic [1:0] smode, input logic [1:0] srot,
                             input logic [1:0] sflip, input logic [7:0] sin, input logic sce3);
      for (int k = 0; k < 2; k++) begin
         int   deb;
         logic ce_k;
         deb  = (k == 0) ? 1 : 3;
         ce_k = (k == 0) ? 1'b1 : sce3;
         for (int p = 0; p < 2; p++) begin
            logic [3:0] held, rise, nmask, nout, raw, rot;
            int r;
            if (!srst_n) begin
               m_s1[k][p] = 4'b0; m_s2[k][p] = 4'b0; m_stable[k][p] = 4'b0; m_sdel[k][p] = 4'b0;
               m_mask[k][p] = 4'b0; m_out[k][p] = 4'b0; m_chg[k][p] = 1'b0;
               for (int b = 0; b < 4; b++) m_cnt[k][p][b] = 0;
            end else begin
               held = m_stable[k][p];
               rise = held & ~m_sdel[k][p];
               if (smode == 2'd3) begin
                  held = held & 4'b0011;
                  rise = rise & 4'b0011;
               end
               nmask = m_mask[k][p];
               if (smode != m_mode_q[k] || smode == 2'd0) nmask = 4'b0000;
               else if (smode == 2'd2) begin
                  if ((held & nmask) == 4'b0000) nmask = first_of(held);
               end else begin
                  if (rise != 4'b0000) nmask = first_of(rise);
                  else if ((held & nmask) == 4'b0000) nmask = first_of(held);
               end
               if (smode == 2'd0) begin
                  nout = held;
                  if (held[3] && held[2]) nout[3:2] = 2'b00;
                  if (held[1] && held[0]) nout[1:0] = 2'b00;
               end else begin
                  nout = held & nmask;
               end
               m_chg[k][p]  = (nout != m_out[k][p]);
               m_out[k][p]  = nout;
               m_mask[k][p] = nmask;
               m_sdel[k][p] = m_stable[k][p];
               for (int b = 0; b < 4; b++) begin
                  if (m_s2[k][p][b] == m_stable[k][p][b]) m_cnt[k][p][b] = 0;
                  else if (ce_k) begin
                     m_cnt[k][p][b] = m_cnt[k][p][b] + 1;
                     if (m_cnt[k][p][b] == deb) begin
                        m_stable[k][p][b] = m_s2[k][p][b];
                        m_cnt[k][p][b]    = 0;
                     end
                  end
               end
               raw = sin[4*p +: 4];
               r   = (int'(srot) + 2 * int'(sflip[p])) % 4;
               rot = 4'b0000;
               for (int a = 0; a < 4; a++) rot[ang2bit[(a + r) % 4]] = raw[ang2bit[a]];
               m_s2[k][p] = m_s1[k][p];
               m_s1[k][p] = rot;
            end
         end
         m_mode_q[k] = srst_n ? smode : 2'd0;
      end
   endtask

   task automatic tick();
      logic       s_rst;
      logic [1:0] s_mode, s_rot, s_flip;
      logic [7:0] s_in;
      logic       s_ce3;
      s_rst = rst_n; s_mode = mode; s_rot = rotate; s_flip = flip; s_in = in_dir; s_ce3 = ce3;
      @(posedge clk);
      model_step(s_rst, s_mode, s_rot, s_flip, s_in, s_ce3);
      #1;
      cyc = cyc + 1;
      if (ce3_rand) ce3 = 1'($urandom_range(0, 1));
      else ce3 = ((cyc % 4) == 3);
   endtask

   task automatic hold(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      hold(3);
      checks++;
      if (bus1.out_dir !== 8'h00) begin errors++; $display("FAIL reset_out1: got %b want 00000000", bus1.out_dir); end
      checks++;
      if (bus1.changed !== 2'b00) begin errors++; $display("FAIL reset_chg1: got %b want 00", bus1.changed); end
      checks++;
      if (bus3.out_dir !== 8'h00) begin errors++; $display("FAIL reset_out3: got %b want 00000000", bus3.out_dir); end
      rst_n = 1'b1;
      mode  = 2'd1;
      hold(3);
   endtask

   task automatic test_latency();
      in_dir = 8'b0000_1000;
      for (int c = 1; c <= 5; c++) begin
         tick();
         checks++;
         if (bus1.out_dir[3:0] !== ((c >= 4) ? 4'b1000 : 4'b0000)) begin
            errors++; $display("FAIL latency_out c=%0d: got %b", c, bus1.out_dir[3:0]);
         end
         checks++;
         if (bus1.changed !== ((c == 4) ? 2'b01 : 2'b00)) begin
            errors++; $display("FAIL latency_chg c=%0d: got %b", c, bus1.changed);
         end
      end
   endtask

   task automatic test_mode1();
      in_dir = 8'b0000_1001;
      hold(6);
      checks++;
      if (bus1.out_dir[3:0] !== 4'b0001) begin errors++; $display("FAIL m1_steal: got %b want 0001", bus1.out_dir[3:0]); end
      in_dir = 8'b0000_1000;
      hold(6);
      checks++;
      if (bus1.out_dir[3:0] !== 4'b1000) begin errors++; $display("FAIL m1_fallback: got %b want 1000", bus1.out_dir[3:0]); end
      checks++;
      if (bus1.out_dir[7:4] !== 4'b0000) begin errors++; $display("FAIL m1_p1_idle: got %b want 0000", bus1.out_dir[7:4]); end
      in_dir = 8'b0000_0000;
      hold(6);
      checks++;
      if (bus1.out_dir[3:0] !== 4'b0000) begin errors++; $display("FAIL m1_release: got %b want 0000", bus1.out_dir[3:0]); end
   endtask

   task automatic test_mode2();
      mode = 2'd2;
      hold(3);
      in_dir = 8'b0000_0010;
      hold(6);
      checks++;
      if (bus1.out_dir[3:0] !== 4'b0010) begin errors++; $display("FAIL m2_left: got %b want 0010", bus1.out_dir[3:0]); end
      in_dir = 8'b0000_1010;
      hold(6);
      checks++;
      if (bus1.out_dir[3:0] !== 4'b0010) begin errors++; $display("FAIL m2_no_steal: got %b want 0010", bus1.out_dir[3:0]); end
      in_dir = 8'b0000_1000;
      hold(6);
      checks++;
      if (bus1.out_dir[3:0] !== 4'b1000) begin errors++; $display("FAIL m2_next: got %b want 1000", bus1.out_dir[3:0]); end
      in_dir = 8'b0000_0000;
      hold(6);
   endtask

   task automatic test_mode0_mode3();
      mode = 2'd0;
      hold(2);
      in_dir = 8'b1110_1101;
      hold(6);
      checks++;
      if (bus1.out_dir !== 8'b0010_0001) begin errors++; $display("FAIL m0_cancel: got %b want 00100001", bus1.out_dir); end
      mode   = 2'd3;
      in_dir = 8'b0000_1000;
      hold(6);
      checks++;
      if (bus1.out_dir[3:0] !== 4'b0000) begin errors++; $display("FAIL m3_up: got %b want 0000", bus1.out_dir[3:0]); end
      in_dir = 8'b0000_1010;
      hold(6);
      checks++;
      if (bus1.out_dir[3:0] !== 4'b0010) begin errors++; $display("FAIL m3_left: got %b want 0010", bus1.out_dir[3:0]); end
      in_dir = 8'b0000_0000;
      hold(6);
   endtask

   task automatic test_rotate();
      mode   = 2'd1;
      rotate = 2'd1;
      flip   = 2'b10;
      hold(6);
      in_dir = 8'b1000_1000;
      hold(6);
      checks++;
      if (bus1.out_dir[3:0] !== 4'b0001) begin errors++; $display("FAIL rot_p0: got %b want 0001", bus1.out_dir[3:0]); end
      checks++;
      if (bus1.out_dir[7:4] !== 4'b0010) begin errors++; $display("FAIL rot_p1: got %b want 0010", bus1.out_dir[7:4]); end
      in_dir = 8'b0000_0000;
      rotate = 2'd0;
      flip   = 2'b00;
      hold(6);
   endtask

   task automatic test_glitch_reset();
      mode = 2'd0;
      hold(30);
      checks++;
      if (bus3.out_dir !== 8'h00) begin errors++; $display("FAIL glitch_pre: got %b want 00000000", bus3.out_dir); end
      in_dir = 8'b0000_0010;
      hold(4);
      in_dir = 8'b0000_0000;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (bus3.out_dir !== 8'h00) begin errors++; $display("FAIL glitch_out i=%0d: got %b", i, bus3.out_dir); end
      end
      in_dir = 8'b0000_0010;
      hold(20);
      checks++;
      if (bus3.out_dir[3:0] !== 4'b0010) begin errors++; $display("FAIL deb3_left: got %b want 0010", bus3.out_dir[3:0]); end
      in_dir = 8'b0000_0000;
      hold(7);
      rst_n = 1'b0;
      tick();
      checks++;
      if (bus3.out_dir !== 8'h00) begin errors++; $display("FAIL midreset_out: got %b want 00000000", bus3.out_dir); end
      checks++;
      if (bus3.changed !== 2'b00) begin errors++; $display("FAIL midreset_chg: got %b want 00", bus3.changed); end
      rst_n  = 1'b1;
      in_dir = 8'b0000_0010;
      for (int i = 0; i < 30; i++) begin
         tick();
         checks++;
         if (bus3.out_dir !== model_out(1)) begin
            errors++; $display("FAIL postreset_out i=%0d: got %b want %b", i, bus3.out_dir, model_out(1));
         end
      end
      in_dir = 8'b0000_0000;
      hold(20);
   endtask

   task automatic test_random();
      ce3_rand = 1'b1;
      for (int seg = 0; seg < 10; seg++) begin
         mode   = 2'($urandom_range(0, 3));
         rotate = 2'($urandom_range(0, 3));
         flip   = 2'($urandom_range(0, 3));
         for (int t = 0; t < 50; t++) begin
            if ($urandom_range(0, 7) == 0) in_dir = 8'($urandom_range(0, 255));
            else if ($urandom_range(0, 9) == 0) in_dir[$urandom_range(0, 7)] = ~in_dir[0];
            rst_n = !(seg == 6 && t == 25);
            tick();
            for (int k = 0; k < 2; k++) begin
               logic [7:0] got_o;
               logic [1:0] got_c;
               got_o = (k == 0) ? bus1.out_dir : bus3.out_dir;
               got_c = (k == 0) ? bus1.changed : bus3.changed;
               checks++;
               if (got_o !== model_out(k)) begin
                  errors++; $display("FAIL rand_out k=%0d seg=%0d t=%0d: got %b want %b", k, seg, t, got_o, model_out(k));
               end
               checks++;
               if (got_c !== model_chg(k)) begin
                  errors++; $display("FAIL rand_chg k=%0d seg=%0d t=%0d: got %b want %b", k, seg, t, got_c, model_chg(k));
               end
            end
         end
      end
      rst_n = 1'b1;
   endtask

   initial begin
      errors = 0; checks = 0; cyc = 0;
      rst_n = 1'b0; mode = 2'd1; rotate = 2'd0; flip = 2'b00; in_dir = 8'h00;
      ce3 = 1'b0; ce3_rand = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_mode_q[k] = 2'd0;
         for (int p = 0; p < 2; p++) begin
            m_s1[k][p] = 4'b0; m_s2[k][p] = 4'b0; m_stable[k][p] = 4'b0; m_sdel[k][p] = 4'b0;
            m_mask[k][p] = 4'b0; m_out[k][p] = 4'b0; m_chg[k][p] = 1'b0;
            for (int b = 0; b < 4; b++) m_cnt[k][p][b] = 0;
         end
      end
      test_reset();
      test_latency();
      test_mode1();
      test_mode2();
      test_mode0_mode3();
      test_rotate();
      test_glitch_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
